selector3_arbiter: RTL and testbench
====================================

Name: selector3_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 3-way, 16-bit selection datapath.
- Three requesters compete for one output bus. The block grants one at a time and drives the 2-bit select code.
- It also registers the selected word and flags it valid.
- A hold limit prevents one requester from starving the others.

Parameters:
- bits, 16, data width of each input word and of the output word.
- MAX_HOLD, 8, maximum consecutive granted cycles while another requester waits. Legal range 1..255.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req  input  3  request lines; Req[i] is requester i.
- Input0  input  bits  data word of requester 0.
- Input1  input  bits  data word of requester 1.
- Input2  input  bits  data word of requester 2.
- Grant  output  3  one-hot grant, registered; all zero when idle.
- Sel  output  2  select code, registered: 00/01/10 for the owner, 11 when idle.
- Output  output  bits  registered selected word.
- OutValid  output  1  Output holds a granted requester's word.

Behaviour:
- Clocking and reset:
  - One clock (Clk). Reset is asynchronous, active-high.
  - While Reset is high: Grant=000, Sel=11, Output=0, OutValid=0, state=IDLE, HoldCnt=0, Last=2 (so requester 0 has top priority first).
  - Reset asserted mid-grant clears everything immediately. There is no completion of the in-flight word.
- State IDLE (Grant=000, Sel=11):
  - At an edge with Req != 000, pick the winner: the first set Req[i] scanning cyclically from Last+1.
  - Go to BUSY with Grant=onehot(winner), Sel=winner, HoldCnt=0.
  - Latency: Req high at edge N gives Grant at edge N, visible in cycle N+1.
- State BUSY (owner = Sel):
  - Release: at an edge with Req[owner]=0, set Last=owner.
    - If any other Req is set, grant the next winner at that same edge with no idle bubble (HoldCnt=0).
    - Otherwise go to IDLE.
  - Forced rotation: at an edge with Req[owner]=1, HoldCnt=MAX_HOLD-1 and any other Req set:
    - Set Last=owner and grant the next winner by the cyclic scan excluding the owner. HoldCnt=0.
    - The previous owner re-competes normally afterwards.
  - Otherwise keep the grant and increment HoldCnt.
  - HoldCnt saturates at MAX_HOLD-1 when no one else requests. The owner keeps the bus indefinitely.
- Datapath:
  - Each edge: Output <= Input[Sel] using the Sel value current before the edge. Sel=11 gives Output <= 0.
  - OutValid <= (Sel != 11).
  - So Output/OutValid lag Grant/Sel by exactly one cycle.
- Simultaneous events:
  - Release and forced rotation at the same edge: treat as release.
  - Req changes on non-owners never disturb the current grant, except through forced rotation.
- Invariants:
  - Grant is always one-hot or zero.
  - Sel=11 if and only if Grant=000.
  - Grant changes only at clock edges or on Reset.
- Counter width: the minimum number of bits holding MAX_HOLD-1 (at least 1).

Test Plan:
- Reset: Reset=1 with Req=111 -> Grant=000, Sel=11, Output=0, OutValid=0 held. After release, first edge -> Grant=001, Sel=00.
- Single requester: Req=010, Input1=16'hBEEF -> Grant=010 one edge later. Output=BEEF, OutValid=1 the edge after. Req drops -> IDLE, Sel=11 next edge, Output=0, OutValid=0 one edge later.
- Round-robin: Req=111, each owner drops its Req for one cycle after 2 cycles then reasserts -> grant order 0,1,2,0 with no idle cycles between owners.
- Hold limit: MAX_HOLD=8, Req=101 held constant -> owner 0 for exactly 8 cycles, then owner 2 for 8, alternating. Grant never 000.
- Saturation: Req=100 for 20 cycles -> Grant=100 throughout, with no rotation.
- Async reset mid-grant: assert Reset between edges while Grant=010 -> Grant=000, Sel=11, OutValid=0 immediately, without waiting for Clk.

Source files
------------

// File: rtl/selector3_arbiter_if.sv
// ============================================================================
//  Module      : selector3_arbiter_if
//  Description : Request/data/grant bundle for the 3-way selection arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface selector3_arbiter_if #(
    parameter int bits = 16
);
    logic [2:0]      Req;
    logic [bits-1:0] Input0;
    logic [bits-1:0] Input1;
    logic [bits-1:0] Input2;
    logic [2:0]      Grant;
    logic [1:0]      Sel;
    logic [bits-1:0] Output;
    logic            OutValid;

    // Requester side
    modport master (
        output Req, Input0, Input1, Input2,
        input  Grant, Sel, Output, OutValid
    );

    // Arbiter side
    modport slave (
        input  Req, Input0, Input1, Input2,
        output Grant, Sel, Output, OutValid
    );
endinterface

`default_nettype wire

// File: rtl/selector3_arbiter.sv
// ============================================================================
//  Module      : selector3_arbiter
//  Description : Round-robin arbiter with hold limit for a 3-way, registered
//                selection datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module selector3_arbiter #(
    parameter int bits     = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    selector3_arbiter_if.slave bus
);

    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [1:0]        SEL_IDLE  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [1:0]        sel_q, sel_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        last_q, last_d;
    logic [bits-1:0]   out_q, out_d;
    logic              valid_q, valid_d;

    logic [2:0]        others;
    logic              owner_req;
    logic [1:0]        win;

    function automatic logic [1:0] inc3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // First set request scanning cyclically from start; caller guarantees req != 0.
    function automatic logic [1:0] scan_from(input logic [1:0] start, input logic [2:0] req);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            idx = 2'((int'(start) + k) % 3);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        last_d    = last_q;
        win       = 2'd0;
        others    = bus.Req & ~grant_q;
        owner_req = |(bus.Req & grant_q);

        case (state_q)
            ST_IDLE: begin
                if (|bus.Req) begin
                    win     = scan_from(inc3(last_q), bus.Req);
                    state_d = ST_BUSY;
                    grant_d = 3'b001 << win;
                    sel_d   = win;
                    hold_d  = '0;
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    last_d = sel_q;
                    hold_d = '0;
                    if (|others) begin
                        win     = scan_from(inc3(sel_q), others);
                        grant_d = 3'b001 << win;
                        sel_d   = win;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 3'b000;
                        sel_d   = SEL_IDLE;
                    end
                end else if ((hold_q == HOLD_LAST) && (|others)) begin
                    // Forced rotation: the owner is excluded from this scan only.
                    last_d  = sel_q;
                    win     = scan_from(inc3(sel_q), others);
                    grant_d = 3'b001 << win;
                    sel_d   = win;
                    hold_d  = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                sel_d   = SEL_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Output word follows the select code that was in force before the edge.
    always_comb begin
        out_d   = '0;
        valid_d = (sel_q != SEL_IDLE);
        case (sel_q)
            2'd0:    out_d = bus.Input0;
            2'd1:    out_d = bus.Input1;
            2'd2:    out_d = bus.Input2;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            grant_q <= 3'b000;
            sel_q   <= SEL_IDLE;
            hold_q  <= '0;
            last_q  <= 2'd2;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Grant    = grant_q;
    assign bus.Sel      = sel_q;
    assign bus.Output   = out_q;
    assign bus.OutValid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_selector3_arbiter.sv
// ============================================================================
//  Module      : tb_selector3_arbiter
//  Description : Scoreboard bench for the 3-way round-robin selection arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_selector3_arbiter;

    localparam logic [15:0] D0 = 16'hA0A0;
    localparam logic [15:0] D1 = 16'hB1B1;
    localparam logic [15:0] D2 = 16'hC2C2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    selector3_arbiter_if #(.bits(16)) bus ();

    selector3_arbiter #(
        .bits    (16),
        .MAX_HOLD(8)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus.slave)
    );

    int          total = 0;
    int          bad   = 0;
    logic [21:0] exp_q[$];

    // Record layout: {Grant[2:0], Sel[1:0], OutValid, Output[15:0]}
    function automatic logic [21:0] rec(input logic [2:0] g, input logic [1:0] s,
                                        input logic v, input logic [15:0] o);
        return {g, s, v, o};
    endfunction

    function automatic logic [21:0] observed();
        return {bus.Grant, bus.Sel, bus.OutValid, bus.Output};
    endfunction

    function automatic logic [15:0] word_of(input int owner);
        return (owner == 0) ? D0 : (owner == 1) ? D1 : D2;
    endfunction

    task automatic test_reset();
        logic [21:0] got, want;
        logic [2:0]  reqs [3];
        logic [21:0] exps [3];
        bus.Req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(rec(3'b000, 2'b11, 1'b0, 16'h0));
            @(posedge clk); #1;
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_hold step=%0d got=%h want=%h", i, got, want);
            end
        end
        rst  = 1'b0;
        reqs = '{3'b111, 3'b000, 3'b000};
        exps = '{rec(3'b001, 2'b00, 1'b0, 16'h0),
                 rec(3'b000, 2'b11, 1'b1, D0),
                 rec(3'b000, 2'b11, 1'b0, 16'h0)};
        for (int i = 0; i < 3; i++) begin
            bus.Req = reqs[i];
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_release step=%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_single_requester();
        logic [21:0] got, want;
        logic [2:0]  reqs [4];
        logic [21:0] exps [4];
        bus.Input1 = 16'hBEEF;
        reqs = '{3'b010, 3'b010, 3'b000, 3'b000};
        exps = '{rec(3'b010, 2'b01, 1'b0, 16'h0),
                 rec(3'b010, 2'b01, 1'b1, 16'hBEEF),
                 rec(3'b000, 2'b11, 1'b1, 16'hBEEF),
                 rec(3'b000, 2'b11, 1'b0, 16'h0)};
        for (int i = 0; i < 4; i++) begin
            bus.Req = reqs[i];
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL single_req step=%0d got=%h want=%h", i, got, want);
            end
        end
        bus.Input1 = D1;
    endtask

    task automatic test_round_robin();
        logic [21:0] got, want;
        logic [2:0]  reqs [10];
        logic [21:0] exps [10];
        rst = 1'b1; #1; rst = 1'b0;
        reqs = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101,
                 3'b111, 3'b011, 3'b111, 3'b000, 3'b000};
        exps = '{rec(3'b001, 2'b00, 1'b0, 16'h0),
                 rec(3'b001, 2'b00, 1'b1, D0),
                 rec(3'b010, 2'b01, 1'b1, D0),
                 rec(3'b010, 2'b01, 1'b1, D1),
                 rec(3'b100, 2'b10, 1'b1, D1),
                 rec(3'b100, 2'b10, 1'b1, D2),
                 rec(3'b001, 2'b00, 1'b1, D2),
                 rec(3'b001, 2'b00, 1'b1, D0),
                 rec(3'b000, 2'b11, 1'b1, D0),
                 rec(3'b000, 2'b11, 1'b0, 16'h0)};
        for (int i = 0; i < 10; i++) begin
            bus.Req = reqs[i];
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL round_robin step=%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [21:0] got, want;
        int          owner, prev;
        rst = 1'b1; #1; rst = 1'b0;
        prev = -1;
        for (int k = 0; k < 42; k++) begin
            if (k < 40) begin
                bus.Req = 3'b101;
                owner   = ((k / 8) % 2 == 0) ? 0 : 2;
                exp_q.push_back(rec(3'b001 << owner, 2'(owner), k > 0,
                                    (k > 0) ? word_of(prev) : 16'h0));
            end else begin
                bus.Req = 3'b000;
                owner   = -1;
                exp_q.push_back(rec(3'b000, 2'b11, prev >= 0,
                                    (prev >= 0) ? word_of(prev) : 16'h0));
            end
            prev = owner;
            @(posedge clk); #1;
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL hold_limit step=%0d got=%h want=%h", k, got, want);
            end
        end
    endtask

    task automatic test_saturation();
        logic [21:0] got, want;
        for (int k = 0; k < 22; k++) begin
            if (k < 20) begin
                bus.Req = 3'b100;
                exp_q.push_back(rec(3'b100, 2'b10, k > 0, (k > 0) ? D2 : 16'h0));
            end else begin
                bus.Req = 3'b000;
                exp_q.push_back(rec(3'b000, 2'b11, k == 20, (k == 20) ? D2 : 16'h0));
            end
            @(posedge clk); #1;
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL saturation step=%0d got=%h want=%h", k, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [21:0] got, want;
        logic [21:0] exps [2];
        exps = '{rec(3'b010, 2'b01, 1'b0, 16'h0),
                 rec(3'b010, 2'b01, 1'b1, D1)};
        bus.Req = 3'b010;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL async_pre step=%0d got=%h want=%h", i, got, want);
            end
        end
        // Mid-cycle: well before the next rising edge
        #2 rst = 1'b1;
        exp_q.push_back(rec(3'b000, 2'b11, 1'b0, 16'h0));
        #1;
        got  = observed();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL async_immediate got=%h want=%h", got, want);
        end
        exp_q.push_back(rec(3'b000, 2'b11, 1'b0, 16'h0));
        @(posedge clk); #1;
        got  = observed();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL async_held got=%h want=%h", got, want);
        end
        rst = 1'b0;
    endtask

    task automatic test_three_way_rotation();
        logic [21:0] got, want;
        int          owner, prev;
        prev = -1;
        for (int k = 0; k < 26; k++) begin
            if (k < 24) begin
                bus.Req = 3'b111;
                owner   = (k / 8) % 3;
                exp_q.push_back(rec(3'b001 << owner, 2'(owner), k > 0,
                                    (k > 0) ? word_of(prev) : 16'h0));
            end else begin
                bus.Req = 3'b000;
                owner   = -1;
                exp_q.push_back(rec(3'b000, 2'b11, prev >= 0,
                                    (prev >= 0) ? word_of(prev) : 16'h0));
            end
            prev = owner;
            @(posedge clk); #1;
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL three_way step=%0d got=%h want=%h", k, got, want);
            end
        end
    endtask

    initial begin
        bus.Req    = 3'b000;
        bus.Input0 = D0;
        bus.Input1 = D1;
        bus.Input2 = D2;
        test_reset();
        test_single_requester();
        test_round_robin();
        test_hold_limit();
        test_saturation();
        test_async_reset();
        test_three_way_rotation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
